// File: rtl/pe_ctrl_pkg.sv
// Shared PE controller types: job state encoding and job count width.
package pe_ctrl_pkg;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE, LOADW, LOADA, GAP, START, COMPUTE, SUMS
  } pe_state_e;
endpackage

// File: rtl/buf_rd_seq.sv
// Buffer read burst: count consecutive reads from base, plus the read-data-valid strobe one cycle later.
module buf_rd_seq
  import pe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              go,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last,
  output logic              dvld
);
  logic [CNT_W-1:0] rem;

  assign last = rd_en && (rem == CNT_W'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rem     <= '0;
      dvld    <= 1'b0;
    end else if (clr) begin
      rd_en <= 1'b0;
      dvld  <= 1'b0;
    end else begin
      dvld <= rd_en;
      if (go) begin
        rd_en   <= 1'b1;
        rd_addr <= base;
        rem     <= count;
      end else if (rd_en) begin
        rem <= rem - 1'b1;
        // address wraps naturally at 2^ADDR_W
        if (last) rd_en <= 1'b0;
        else      rd_addr <= rd_addr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pe_ctrl.sv
// PE job controller: loads weights/activations, starts the PE, drains sums.
// Optional COMPUTE watchdog enabled with `define PE_CTRL_TIMEOUT_EN.
module pe_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int RF_DEPTH    = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [CNT_W-1:0]  job_wcount,
  input  logic [CNT_W-1:0]  job_acount,
  input  logic [ADDR_W-1:0] job_wbase,
  input  logic [ADDR_W-1:0] job_abase,
  input  logic              abort,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  logic [DATA_W-1:0] w_rd_data,
  input  logic [DATA_W-1:0] a_rd_data,
  output logic [DATA_W-1:0] pe_weights_o,
  output logic [DATA_W-1:0] pe_acts_o,
  output logic              ctrl_loadw,
  output logic              ctrl_loada,
  output logic              ctrl_start,
  output logic              ctrl_sums,
  output logic [CNT_W-1:0]  ctrl_wcount,
  output logic [CNT_W-1:0]  ctrl_acount,
  input  logic              pe_flag_done,
  output logic              busy,
  output logic              job_done,
  output logic              job_err
);
  pe_state_e         state, next;
  logic [CNT_W-1:0]  sums_cnt;
  logic [ADDR_W-1:0] abase_q;
  logic xfer, bad, kill, tmo;
  logic w_go, a_go, w_last, a_last, a_tail;

  // ready is gated by nrst so nothing can transfer while held in reset
  assign job_ready = (state == IDLE) && nrst;
  assign busy      = (state != IDLE);
  assign xfer      = job_valid && job_ready && !abort;
  assign bad       = (job_wcount == '0) || (job_wcount > job_acount) ||
                     (int'(job_acount) > RF_DEPTH);
  assign kill      = abort && (state != IDLE);

  assign pe_weights_o = ctrl_loadw ? w_rd_data : '0;
  assign pe_acts_o    = ctrl_loada ? a_rd_data : '0;

`ifdef PE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                 tcnt <= '0;
    else if (state != COMPUTE) tcnt <= '0;
    else                       tcnt <= tcnt + 1'b1;
  end

  assign tmo = (state == COMPUTE) && (tcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    next     = state;
    w_go     = 1'b0;
    a_go     = 1'b0;
    job_done = 1'b0;
    job_err  = 1'b0;
    case (state)
      IDLE:    if (xfer) begin
                 if (bad) job_err = 1'b1;
                 else begin next = LOADW; w_go = 1'b1; end
               end
      // activation burst starts on the cycle after the last weight read
      LOADW:   if (w_last) begin next = LOADA; a_go = 1'b1; end
      LOADA:   if (a_tail) next = GAP;
      GAP:     next = START;
      START:   next = COMPUTE;
      COMPUTE: if (pe_flag_done) next = SUMS;
               else if (tmo) begin next = IDLE; job_err = 1'b1; end
      SUMS:    if (sums_cnt == '0) begin next = IDLE; job_done = 1'b1; end
      default: next = IDLE;
    endcase
    if (kill) begin
      next     = IDLE;
      w_go     = 1'b0;
      a_go     = 1'b0;
      job_done = 1'b0;
      job_err  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      ctrl_start  <= 1'b0;
      ctrl_sums   <= 1'b0;
      ctrl_wcount <= '0;
      ctrl_acount <= '0;
      abase_q     <= '0;
      sums_cnt    <= '0;
      a_tail      <= 1'b0;
    end else begin
      state      <= next;
      ctrl_start <= (next == START);
      ctrl_sums  <= (next == SUMS);
      a_tail     <= a_last && !kill;
      if (w_go) begin
        ctrl_wcount <= job_wcount;
        ctrl_acount <= job_acount;
        abase_q     <= job_abase;
      end
      // SUMS runs acount-wcount+1 cycles: counter holds the remaining extra ones
      if (state == COMPUTE && pe_flag_done) sums_cnt <= ctrl_acount - ctrl_wcount;
      else if (state == SUMS)               sums_cnt <= sums_cnt - 1'b1;
    end
  end

  buf_rd_seq #(.ADDR_W(ADDR_W)) u_wseq (
    .clk(clk), .nrst(nrst), .clr(kill), .go(w_go),
    .base(job_wbase), .count(job_wcount),
    .rd_en(w_rd_en), .rd_addr(w_rd_addr), .last(w_last), .dvld(ctrl_loadw)
  );

  buf_rd_seq #(.ADDR_W(ADDR_W)) u_aseq (
    .clk(clk), .nrst(nrst), .clr(kill), .go(a_go),
    .base(abase_q), .count(ctrl_acount),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .last(a_last), .dvld(ctrl_loada)
  );
endmodule

// File: tb/tb_pe_ctrl.sv
// Directed vector bench for pe_ctrl (default build, watchdog disabled).
module tb_pe_ctrl;
  logic       clk = 1'b0;
  logic       nrst;
  logic       job_valid, abort, pe_flag_done;
  logic       job_ready, busy, job_done, job_err;
  logic [7:0] job_wcount, job_acount, job_wbase, job_abase;
  logic       w_rd_en, a_rd_en;
  logic [7:0] w_rd_addr, a_rd_addr, w_rd_data, a_rd_data;
  logic [7:0] pe_weights_o, pe_acts_o, ctrl_wcount, ctrl_acount;
  logic       ctrl_loadw, ctrl_loada, ctrl_start, ctrl_sums;
  logic [56:0] outs;

  int checks = 0;
  int errors = 0;

  pe_ctrl dut (
    .clk(clk), .nrst(nrst), .job_valid(job_valid), .job_ready(job_ready),
    .job_wcount(job_wcount), .job_acount(job_acount),
    .job_wbase(job_wbase), .job_abase(job_abase), .abort(abort),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .w_rd_data(w_rd_data), .a_rd_data(a_rd_data),
    .pe_weights_o(pe_weights_o), .pe_acts_o(pe_acts_o),
    .ctrl_loadw(ctrl_loadw), .ctrl_loada(ctrl_loada), .ctrl_start(ctrl_start),
    .ctrl_sums(ctrl_sums), .ctrl_wcount(ctrl_wcount), .ctrl_acount(ctrl_acount),
    .pe_flag_done(pe_flag_done), .busy(busy), .job_done(job_done), .job_err(job_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fw(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction
  function automatic logic [7:0] fa(input logic [7:0] a);
    return a + 8'h33;
  endfunction

  // buffer model: data for the address presented on the previous edge
  always @(posedge clk) begin
    w_rd_data <= fw(w_rd_addr);
    a_rd_data <= fa(a_rd_addr);
  end

  assign outs = {busy, job_done, job_err, ctrl_loadw, ctrl_loada, ctrl_start, ctrl_sums,
                 w_rd_en, a_rd_en, w_rd_addr, a_rd_addr, ctrl_wcount, ctrl_acount,
                 pe_weights_o, pe_acts_o};

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [7:0] wc, ac, wb, ab;
    int err, sums;
  } vec_t;

  int nlw, nla, nst, nsm, ndn, ner, novl, nderr, naddr, nard;
  int c_lastA, c_st, zero_bad, post_bad;

  // mode 0: normal, 1: abort on 2nd LOADA cycle, 2: reset pulse on 2nd SUMS cycle
  task automatic run_job(input vec_t v, input int mode);
    int end_c, wi, ai, wri, ari;
    bit fin, ev, zchk, post;
    nlw = 0; nla = 0; nst = 0; nsm = 0; ndn = 0; ner = 0; novl = 0; nderr = 0;
    naddr = 0; nard = 0; c_lastA = -1; c_st = -1; zero_bad = 0; post_bad = 0;
    wi = 0; ai = 0; wri = 0; ari = 0; fin = 0; ev = 0; zchk = 0; post = 0;
    end_c = 400;
    @(negedge clk);
    job_valid = 1'b1; job_wcount = v.wc; job_acount = v.ac;
    job_wbase = v.wb; job_abase = v.ab;
    for (int c = 0; c < end_c; c++) begin
      #1;
      if (post && (ctrl_loadw || ctrl_loada || ctrl_start || ctrl_sums || busy)) post_bad++;
      if (w_rd_en) begin if (w_rd_addr !== 8'(v.wb + wri)) naddr++; wri++; end
      if (a_rd_en) begin if (a_rd_addr !== 8'(v.ab + ari)) naddr++; ari++; nard++; end
      if (ctrl_loadw) begin nlw++; if (pe_weights_o !== fw(8'(v.wb + wi))) nderr++; wi++; end
      if (ctrl_loada) begin nla++; if (pe_acts_o !== fa(8'(v.ab + ai))) nderr++; ai++; c_lastA = c; end
      if (ctrl_start) begin nst++; c_st = c; end
      if (ctrl_sums) nsm++;
      if (job_done) ndn++;
      if (job_err) ner++;
      if (int'(ctrl_loadw) + int'(ctrl_loada) + int'(ctrl_start) + int'(ctrl_sums) > 1) novl++;
      if (!fin && (job_done || job_err)) begin fin = 1; end_c = c + 4; end
      if (mode == 1 && !ev && nard == 2) begin abort = 1'b1; ev = 1; end_c = c + 12; end
      if (mode == 2 && !ev && nsm == 2) begin
        ev = 1; nrst = 1'b0; #1;
        if (outs !== '0 || job_ready !== 1'b0) zero_bad++;
        @(posedge clk); #1 nrst = 1'b1; post = 1; end_c = c + 12;
      end
      @(posedge clk); #1;
      job_valid = 1'b0;
      pe_flag_done = 1'b0;
      if (mode == 1 && ev && !zchk) begin
        zchk = 1; abort = 1'b0;
        if (ctrl_loadw || ctrl_loada || ctrl_start || ctrl_sums || w_rd_en || a_rd_en || busy)
          zero_bad++;
      end
      if (c_st >= 0 && c == c_st + 3) pe_flag_done = 1'b1;
      @(negedge clk);
    end
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{8'd3,  8'd6,  8'h10, 8'h20, 0, 4};
    vt[1] = '{8'd4,  8'd3,  8'h10, 8'h20, 1, 0};
    vt[2] = '{8'd3,  8'd3,  8'hFE, 8'hFD, 0, 1};
    vt[3] = '{8'd1,  8'd1,  8'h00, 8'h80, 0, 1};
    vt[4] = '{8'd0,  8'd5,  8'h00, 8'h00, 1, 0};
    vt[5] = '{8'd2,  8'd17, 8'h00, 8'h00, 1, 0};
    vt[6] = '{8'd16, 8'd16, 8'h40, 8'hF8, 0, 1};
    vt[7] = '{8'd1,  8'd16, 8'hFF, 8'h01, 0, 16};

    nrst = 1'b0; job_valid = 1'b0; abort = 1'b0; pe_flag_done = 1'b0;
    job_wcount = '0; job_acount = '0; job_wbase = '0; job_abase = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs_zero", int'(outs != '0), 0);
    chk("rst_ready_low", int'(job_ready), 0);
    nrst = 1'b1; #1;
    chk("rel_ready", int'(job_ready), 1);
    chk("rel_busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) begin
      run_job(vt[i], 0);
      chk($sformatf("v%0d_loadw", i), nlw, vt[i].err ? 0 : int'(vt[i].wc));
      chk($sformatf("v%0d_loada", i), nla, vt[i].err ? 0 : int'(vt[i].ac));
      chk($sformatf("v%0d_start", i), nst, vt[i].err ? 0 : 1);
      chk($sformatf("v%0d_sums", i), nsm, vt[i].sums);
      chk($sformatf("v%0d_done", i), ndn, vt[i].err ? 0 : 1);
      chk($sformatf("v%0d_err", i), ner, vt[i].err);
      chk($sformatf("v%0d_overlap", i), novl, 0);
      chk($sformatf("v%0d_data", i), nderr, 0);
      chk($sformatf("v%0d_addr", i), naddr, 0);
      if (!vt[i].err) chk($sformatf("v%0d_gap", i), c_st - c_lastA - 1, 1);
      chk($sformatf("v%0d_ready_after", i), int'(job_ready), 1);
      chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
    end

    // abort during LOADA, then a clean job
    run_job(vt[0], 1);
    chk("abort_zero", zero_bad, 0);
    chk("abort_no_done", ndn, 0);
    chk("abort_no_start", nst, 0);
    chk("abort_loada", nla, 1);
    run_job(vt[0], 0);
    chk("post_abort_sums", nsm, 4);
    chk("post_abort_done", ndn, 1);

    // abort in IDLE together with a valid job drops it
    @(negedge clk);
    job_valid = 1'b1; abort = 1'b1; job_wcount = 8'd2; job_acount = 8'd2;
    #1 chk("idle_abort_err", int'(job_err), 0);
    @(posedge clk); #1;
    job_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("idle_abort_busy_later", int'(busy), 0);

    // reset pulse during SUMS
    run_job(vt[7], 2);
    chk("rst_sums_zero", zero_bad, 0);
    chk("rst_sums_stray", post_bad, 0);
    chk("rst_sums_no_done", ndn, 0);
    chk("rst_sums_ready", int'(job_ready), 1);
    run_job(vt[3], 0);
    chk("post_rst_done", ndn, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
